composite_video_encoder: RTL
============================

Name: composite_video_encoder

Overview:
- Parametrised next-generation composite encoder. Converts timing strobes plus Y and two chroma components into DAC codes for NTSC or PAL.
- Runs in the DAC/subcarrier phase clock domain, downstream of the timing generator and colour-space converter, and drives the resistor-ladder DAC directly.
- Adds three things the previous generation lacks:
  - runtime NTSC/PAL mode, with per-line PAL V-switch;
  - generic phase/DAC/coefficient widths, with the sine table generated from parameters;
  - output saturation instead of wrap.

Parameters:
- PHASE_BITS, 4, subcarrier phase width; table depth 2^PHASE_BITS.
- DAC_BITS, 5, output code width.
- COEF_BITS, 7, magnitude bits of the signed sine/cosine table (entries are COEF_BITS+1 wide, peak 2^COEF_BITS-1).
- LEVEL_SHIFT, 11, right shift from the internal sum to DAC codes.
- SYNC_LEVEL, 0, sync tip code.
- BLANK_LEVEL, 8, blanking code.
- BLACK_LEVEL, 10, active-video pedestal code (PAL uses BLANK_LEVEL as black).
- NTSC_BURST_A, 35, burst chroma A (NTSC).
- NTSC_BURST_B, -54, burst chroma B (NTSC).
- PAL_BURST_A, -45, burst chroma A (PAL).
- PAL_BURST_B, 45, burst chroma B (PAL), sign flipped by V-switch.

Ports:
- phaseClock  in  1  sample clock; one sample per phase step.
- reset  in  1  synchronous, active-high.
- palMode  in  1  0=NTSC, 1=PAL; sampled only on lineStart.
- lineStart  in  1  one-cycle pulse at each line's leading sync edge.
- subcarrierPhase  in  PHASE_BITS  current subcarrier phase.
- blank  in  1  blanking interval.
- sync  in  1  sync tip.
- burst  in  1  burst gate.
- y  in  8  luma, unsigned.
- chromaA  in  9  signed (I in NTSC, U in PAL).
- chromaB  in  9  signed (Q in NTSC, V in PAL).
- dacSample  out  DAC_BITS  composite code.
- clipped  out  1  high when the current dacSample was saturated.

Behaviour:
- Clocking and reset:
  - Single clock phaseClock. Reset is synchronous and active-high.
  - In the reset cycle and afterwards until new data drains: dacSample=BLANK_LEVEL, clipped=0.
  - Reset also clears palLatched=0, vSwitch=0, and all pipeline registers to the blank state (Y=0, chroma=0, offset=BLANK_LEVEL).
- Mode and V-switch state, updated on lineStart:
  - palLatched<=palMode.
  - vSwitch<=palMode ? ~vSwitch : 0.
  - Mid-line palMode changes are ignored.
  - lineStart coincident with reset: reset wins.
- Stage 1 (select), priority sync > burst > blank > active:
  - sync: offset=SYNC_LEVEL, Y=A=B=0.
  - burst: offset=BLANK_LEVEL, Y=0, A/B = NTSC_BURST_* or PAL_BURST_* per palLatched.
  - blank: offset=BLANK_LEVEL, zeros.
  - active: offset = palLatched ? BLANK_LEVEL : BLACK_LEVEL; Y=y, A=chromaA, B=chromaB.
  - Also register cos/sin[subcarrierPhase], where sin[p]=cos[p - 2^(PHASE_BITS-2)].
  - In PAL, negate B when vSwitch=1 (applies to both burst and video).
- Stage 2 (multiply):
  - yComp = Y<<COEF_BITS.
  - aComp = A*cos.
  - bComp = B*sin.
  - offScaled = (offset<<LEVEL_SHIFT) + (1<<(LEVEL_SHIFT-1)) for rounding.
- Stage 3 (sum): signed sum with width max(components)+2; no overflow for any legal input.
- Stage 4 (output):
  - s = sum>>>LEVEL_SHIFT (arithmetic).
  - s<0: dacSample=0, clipped=1.
  - s>2^DAC_BITS-1: dacSample=all ones, clipped=1.
  - otherwise dacSample=s, clipped=0.
- Latency: exactly 4 phaseClock cycles from input to dacSample, identical for strobes, data and phase, so burst and video stay phase-coherent.
- Phase wraps modulo 2^PHASE_BITS. Consecutive phase values need not be adjacent.

Decomposition:
- Package composite_video_pkg holds:
  - the mode enum (MODE_NTSC, MODE_PAL);
  - a function building the cosine ROM for given PHASE_BITS/COEF_BITS (round(peak*cos(2πk/N)));
  - default level and burst constants.
- One sub-module, composite_clamp_round: stage-4 shift/saturate plus the clipped flag, parametrised on input width, LEVEL_SHIFT and DAC_BITS.

Test Plan:
- Reset then sync=1 for 10 cycles -> dacSample=8 through reset, then 0 from cycle 4 on; clipped=0.
- NTSC defaults, active, y=0, chroma 0 -> 10. Same with y=255 -> 10+floor(32640/2048+0.5)=26.
- NTSC, y=255, chromaA=152, chromaB=0, phase=0 (cos 127) -> raw 35, dacSample=31, clipped=1. Same at phase=8 -> 26-9=17, clipped=0.
- NTSC burst, phases 0..15 stepped -> mean code 8, peak-to-peak ≈ ±4 codes, pattern repeats every 16 samples, 4-cycle latency.
- PAL mode, two lineStart pulses with burst at phase 0 each line -> B-term sign alternates between lines. palMode toggled mid-line -> no effect until next lineStart.
- Reset asserted mid-active-line with y=200 -> next cycle dacSample=8, vSwitch=0, pipeline flushed. First output after reset release appears 4 cycles later.

Source files
------------

// File: rtl/composite_video_pkg.sv
// Shared types, default levels and the cosine table generator for the composite encoder.
package composite_video_pkg;

    typedef enum logic {
        MODE_NTSC = 1'b0,
        MODE_PAL  = 1'b1
    } mode_e;

    localparam int DEF_SYNC_LEVEL   = 0;
    localparam int DEF_BLANK_LEVEL  = 8;
    localparam int DEF_BLACK_LEVEL  = 10;
    localparam int DEF_NTSC_BURST_A = 35;
    localparam int DEF_NTSC_BURST_B = -54;
    localparam int DEF_PAL_BURST_A  = -45;
    localparam int DEF_PAL_BURST_B  = 45;

    localparam real PI = 3.14159265358979323846;

    // Entry k of round(peak*cos(2*pi*k/N)), N = 2^phase_bits, peak = 2^coef_bits-1.
    function automatic int cos_coef(input int k, input int phase_bits, input int coef_bits);
        real v_peak;
        real v_val;
        v_peak = $itor((1 << coef_bits) - 1);
        v_val  = v_peak * $cos(2.0 * PI * $itor(k) / $itor(1 << phase_bits));
        if (v_val >= 0.0) begin
            return $rtoi(v_val + 0.5);
        end
        return -$rtoi(0.5 - v_val);
    endfunction

endpackage

// File: rtl/composite_clamp_round.sv
// Output stage: arithmetic shift of the composite sum down to DAC codes with saturation.
module composite_clamp_round #(
    parameter int IN_W        = 20,
    parameter int LEVEL_SHIFT = 11,
    parameter int DAC_BITS    = 5,
    parameter int RESET_CODE  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic signed [IN_W-1:0]     i_sum,
    output logic        [DAC_BITS-1:0] o_dac_sample,
    output logic                       o_clipped
);

    localparam logic signed [IN_W-1:0] MAX_CODE = IN_W'((1 << DAC_BITS) - 1);

    logic signed [IN_W-1:0]     w_shifted;
    logic        [DAC_BITS-1:0] w_code;
    logic                       w_clip;

    assign w_shifted = i_sum >>> LEVEL_SHIFT;

    always_comb begin
        w_code = w_shifted[DAC_BITS-1:0];
        w_clip = 1'b0;
        if (w_shifted[IN_W-1]) begin
            w_code = '0;
            w_clip = 1'b1;
        end else if (w_shifted > MAX_CODE) begin
            w_code = '1;
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dac_sample <= DAC_BITS'(RESET_CODE);
            o_clipped    <= 1'b0;
        end else begin
            o_dac_sample <= w_code;
            o_clipped    <= w_clip;
        end
    end

endmodule

// File: rtl/composite_video_encoder.sv
// NTSC/PAL composite encoder: select, modulate, sum and saturate in a fixed 4-cycle pipeline.
module composite_video_encoder
    import composite_video_pkg::*;
#(
    parameter int PHASE_BITS   = 4,
    parameter int DAC_BITS     = 5,
    parameter int COEF_BITS    = 7,
    parameter int LEVEL_SHIFT  = 11,
    parameter int SYNC_LEVEL   = DEF_SYNC_LEVEL,
    parameter int BLANK_LEVEL  = DEF_BLANK_LEVEL,
    parameter int BLACK_LEVEL  = DEF_BLACK_LEVEL,
    parameter int NTSC_BURST_A = DEF_NTSC_BURST_A,
    parameter int NTSC_BURST_B = DEF_NTSC_BURST_B,
    parameter int PAL_BURST_A  = DEF_PAL_BURST_A,
    parameter int PAL_BURST_B  = DEF_PAL_BURST_B
) (
    input  logic                         i_phase_clock,
    input  logic                         i_reset,
    input  logic                         i_pal_mode,
    input  logic                         i_line_start,
    input  logic        [PHASE_BITS-1:0] i_subcarrier_phase,
    input  logic                         i_blank,
    input  logic                         i_sync,
    input  logic                         i_burst,
    input  logic        [7:0]            i_y,
    input  logic signed [8:0]            i_chroma_a,
    input  logic signed [8:0]            i_chroma_b,
    output logic        [DAC_BITS-1:0]   o_dac_sample,
    output logic                         o_clipped
);

    localparam int ROM_DEPTH  = 1 << PHASE_BITS;
    localparam int COEF_W     = COEF_BITS + 1;
    // One extra bit so that negating chroma B = -256 cannot overflow.
    localparam int CHROMA_W   = 10;
    localparam int Y_COMP_W   = 8 + COEF_BITS + 1;
    localparam int PROD_W     = CHROMA_W + COEF_W;
    localparam int OFF_W      = DAC_BITS + LEVEL_SHIFT + 1;
    localparam int MAX_A      = (Y_COMP_W > PROD_W) ? Y_COMP_W : PROD_W;
    localparam int MAX_W      = (MAX_A > OFF_W) ? MAX_A : OFF_W;
    localparam int SUM_W      = MAX_W + 2;
    localparam int ROUND_BIAS = 1 << (LEVEL_SHIFT - 1);

    localparam logic signed [OFF_W-1:0] BLANK_SCALED =
        OFF_W'((BLANK_LEVEL << LEVEL_SHIFT) + ROUND_BIAS);

    logic signed [COEF_W-1:0] w_cos_rom [ROM_DEPTH];

    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam logic signed [COEF_W-1:0] COEF_VAL =
            COEF_W'(cos_coef(g, PHASE_BITS, COEF_BITS));
        assign w_cos_rom[g] = COEF_VAL;
    end

    mode_e r_pal_latched;
    logic  r_v_switch;

    always_ff @(posedge i_phase_clock) begin
        if (i_reset) begin
            r_pal_latched <= MODE_NTSC;
            r_v_switch    <= 1'b0;
        end else if (i_line_start) begin
            r_pal_latched <= i_pal_mode ? MODE_PAL : MODE_NTSC;
            r_v_switch    <= i_pal_mode ? ~r_v_switch : 1'b0;
        end
    end

    // Stage 1: select levels and components, look up the carrier.
    logic        [DAC_BITS-1:0]   w_sel_off;
    logic        [7:0]            w_sel_y;
    logic signed [CHROMA_W-1:0]   w_sel_a;
    logic signed [CHROMA_W-1:0]   w_sel_b_raw;
    logic signed [CHROMA_W-1:0]   w_sel_b;
    logic        [PHASE_BITS-1:0] w_sin_idx;
    logic                         w_is_pal;

    assign w_is_pal  = (r_pal_latched == MODE_PAL);
    assign w_sin_idx = i_subcarrier_phase - PHASE_BITS'(ROM_DEPTH / 4);

    always_comb begin
        w_sel_off   = DAC_BITS'(BLANK_LEVEL);
        w_sel_y     = '0;
        w_sel_a     = '0;
        w_sel_b_raw = '0;
        if (i_sync) begin
            w_sel_off = DAC_BITS'(SYNC_LEVEL);
        end else if (i_burst) begin
            if (w_is_pal) begin
                w_sel_a     = CHROMA_W'(PAL_BURST_A);
                w_sel_b_raw = CHROMA_W'(PAL_BURST_B);
            end else begin
                w_sel_a     = CHROMA_W'(NTSC_BURST_A);
                w_sel_b_raw = CHROMA_W'(NTSC_BURST_B);
            end
        end else if (!i_blank) begin
            w_sel_off   = w_is_pal ? DAC_BITS'(BLANK_LEVEL) : DAC_BITS'(BLACK_LEVEL);
            w_sel_y     = i_y;
            w_sel_a     = CHROMA_W'(i_chroma_a);
            w_sel_b_raw = CHROMA_W'(i_chroma_b);
        end
        w_sel_b = (w_is_pal && r_v_switch) ? -w_sel_b_raw : w_sel_b_raw;
    end

    logic        [DAC_BITS-1:0] r_s1_off;
    logic        [7:0]          r_s1_y;
    logic signed [CHROMA_W-1:0] r_s1_a;
    logic signed [CHROMA_W-1:0] r_s1_b;
    logic signed [COEF_W-1:0]   r_s1_cos;
    logic signed [COEF_W-1:0]   r_s1_sin;

    always_ff @(posedge i_phase_clock) begin
        if (i_reset) begin
            r_s1_off <= DAC_BITS'(BLANK_LEVEL);
            r_s1_y   <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_cos <= '0;
            r_s1_sin <= '0;
        end else begin
            r_s1_off <= w_sel_off;
            r_s1_y   <= w_sel_y;
            r_s1_a   <= w_sel_a;
            r_s1_b   <= w_sel_b;
            r_s1_cos <= w_cos_rom[i_subcarrier_phase];
            r_s1_sin <= w_cos_rom[w_sin_idx];
        end
    end

    // Stage 2: scale luma and offset, modulate chroma onto the carrier.
    logic signed [Y_COMP_W-1:0] w_y_comp;
    logic signed [PROD_W-1:0]   w_a_comp;
    logic signed [PROD_W-1:0]   w_b_comp;
    logic signed [OFF_W-1:0]    w_off_scaled;

    assign w_y_comp     = $signed(Y_COMP_W'({1'b0, r_s1_y}) << COEF_BITS);
    assign w_a_comp     = PROD_W'(r_s1_a) * PROD_W'(r_s1_cos);
    assign w_b_comp     = PROD_W'(r_s1_b) * PROD_W'(r_s1_sin);
    assign w_off_scaled = $signed((OFF_W'(r_s1_off) << LEVEL_SHIFT) + OFF_W'(ROUND_BIAS));

    logic signed [Y_COMP_W-1:0] r_s2_y;
    logic signed [PROD_W-1:0]   r_s2_a;
    logic signed [PROD_W-1:0]   r_s2_b;
    logic signed [OFF_W-1:0]    r_s2_off;

    always_ff @(posedge i_phase_clock) begin
        if (i_reset) begin
            r_s2_y   <= '0;
            r_s2_a   <= '0;
            r_s2_b   <= '0;
            r_s2_off <= BLANK_SCALED;
        end else begin
            r_s2_y   <= w_y_comp;
            r_s2_a   <= w_a_comp;
            r_s2_b   <= w_b_comp;
            r_s2_off <= w_off_scaled;
        end
    end

    // Stage 3: composite sum, wide enough that no legal input overflows.
    logic signed [SUM_W-1:0] r_s3_sum;

    always_ff @(posedge i_phase_clock) begin
        if (i_reset) begin
            r_s3_sum <= SUM_W'(BLANK_SCALED);
        end else begin
            r_s3_sum <= SUM_W'(r_s2_y) + SUM_W'(r_s2_a) + SUM_W'(r_s2_b) + SUM_W'(r_s2_off);
        end
    end

    composite_clamp_round #(
        .IN_W        (SUM_W),
        .LEVEL_SHIFT (LEVEL_SHIFT),
        .DAC_BITS    (DAC_BITS),
        .RESET_CODE  (BLANK_LEVEL)
    ) u_clamp (
        .i_clk        (i_phase_clock),
        .i_reset      (i_reset),
        .i_sum        (r_s3_sum),
        .o_dac_sample (o_dac_sample),
        .o_clipped    (o_clipped)
    );

endmodule
